if_fetch_stage: RTL and testbench

Instruction-fetch stage that feeds the ID stage of the in-order pipeline. It owns the fetch PC, issues one read per cycle to a synchronous instruction SRAM with fixed 1-cycle latency, and buffers returned {pc, inst} pairs in a 2-entry FIFO. It honours the hazard unit's ID stall (`id_write_en`) as backpressure and its branch flush (`id_flush` plus target) as a redirect.

---
 rtl/if_fetch_stage_if.sv | 33 +++
 rtl/if_fetch_stage.sv | 109 ++++++++++
 tb/tb_if_fetch_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// ============================================================================
// Module      : if_fetch_stage_if
// Description : Bundle of signals between the fetch stage, the instruction
//               SRAM, the hazard unit and the ID stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface if_fetch_stage_if;
  logic        id_write_en;
  logic        id_flush;
  logic [31:0] redirect_pc;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  // Fetch-stage side
  modport master (
    input  id_write_en, id_flush, redirect_pc, inst_sram_rdata,
    output inst_sram_en, inst_sram_addr, if_valid, if_pc, if_inst
  );

  // Environment side (hazard unit, ID stage, SRAM)
  modport slave (
    output id_write_en, id_flush, redirect_pc, inst_sram_rdata,
    input  inst_sram_en, inst_sram_addr, if_valid, if_pc, if_inst
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction fetch stage. Issues one read per cycle to a
//               1-cycle-latency instruction SRAM and buffers returned
//               {pc, inst} pairs in a 2-entry FIFO feeding ID.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  if_fetch_stage_if.master bus
);

  logic [31:0] pc_f_q, pc_f_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] fifo_pc_q   [2];
  logic [31:0] fifo_inst_q [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        pop;
  logic        push;
  logic        issue;
  logic [31:0] issue_addr;
  logic [2:0]  occupancy;

  // Handshake decode, issue decision and next-state computation
  always_comb begin
    pop        = (count_q != 2'd0) & bus.id_write_en & ~bus.id_flush;
    push       = inflight_q & ~bus.id_flush;
    // Slots that will be taken once the in-flight word lands; issuing only
    // when at most one is taken leaves room for the word issued now.
    occupancy  = {1'b0, count_q} + {2'b00, inflight_q};
    issue      = bus.id_flush | (occupancy <= (3'd1 + {2'b00, pop}));
    issue_addr = bus.id_flush ? bus.redirect_pc : pc_f_q;

    pc_f_d        = pc_f_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (bus.id_flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push) wr_ptr_d = ~wr_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = issue_addr;
      pc_f_d        = issue_addr + 32'd4;
    end
  end

  // SRAM request and ID-facing outputs; the head comes straight from storage
  always_comb begin
    bus.inst_sram_en   = issue & ~rst;
    bus.inst_sram_addr = {issue_addr[31:2], 2'b00};
    bus.if_valid       = (count_q != 2'd0);
    bus.if_pc          = bus.if_valid ? fifo_pc_q[rd_ptr_q]   : 32'd0;
    bus.if_inst        = bus.if_valid ? fifo_inst_q[rd_ptr_q] : 32'd0;
  end

  // Control state; reset drops buffered and in-flight data on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q        <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      pc_f_q        <= pc_f_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage; validity is tracked by count, so the payload needs no reset
  always_ff @(posedge clk) begin
    if (push & ~rst) begin
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
      fifo_inst_q[wr_ptr_q] <= bus.inst_sram_rdata;
    end
  end

  // A push into a full FIFO without a matching pop would lose an instruction
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == 2'd2) && !pop));

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Self-checking bench for if_fetch_stage: directed vector table,
//               a reset-while-buffered sequence, and randomized traffic checked
//               against a queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;
  localparam logic [31:0] B = 32'h1c00_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_PC(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Instruction SRAM: 1-cycle latency, returns the address as the data.
  // Idle cycles return garbage so any use of non-requested data shows up.
  always @(posedge clk)
    bus.inst_sram_rdata <= bus.inst_sram_en ? bus.inst_sram_addr : $urandom();

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic        we;
    logic        fl;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] pc;
    logic        en;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic we, logic fl, logic [31:0] rpc,
                              logic v, logic [31:0] pc, logic en, logic [31:0] addr);
    vec_t r;
    r.we = we; r.fl = fl; r.rpc = rpc; r.valid = v; r.pc = pc; r.en = en; r.addr = addr;
    vecs.push_back(r);
  endfunction

  task automatic drive(input logic r, input logic we, input logic fl, input logic [31:0] rpc);
    @(negedge clk);
    rst             = r;
    bus.id_write_en = we;
    bus.id_flush    = fl;
    bus.redirect_pc = rpc;
    #2;
  endtask

  task automatic chk_outputs(input string tag, input logic v, input logic [31:0] pc,
                             input logic en, input logic [31:0] addr);
    chk({tag, " if_valid"}, {31'd0, bus.if_valid}, {31'd0, v});
    chk({tag, " if_pc"}, bus.if_pc, v ? pc : 32'd0);
    chk({tag, " if_inst"}, bus.if_inst, v ? {pc[31:2], 2'b00} : 32'd0);
    chk({tag, " sram_en"}, {31'd0, bus.inst_sram_en}, {31'd0, en});
    if (en) chk({tag, " sram_addr"}, bus.inst_sram_addr, {addr[31:2], 2'b00});
  endtask

  // Reference model state: buffered PCs, in-flight request, next fetch PC
  logic [31:0] m_q[$];
  logic        m_inf;
  logic [31:0] m_inf_pc;
  logic [31:0] m_pcf;

  function automatic logic m_issue(logic we, logic fl);
    int pop;
    pop = (m_q.size() > 0 && we) ? 1 : 0;
    return fl || (m_q.size() + int'(m_inf) - pop <= 1);
  endfunction

  function automatic void m_step(logic r, logic we, logic fl, logic [31:0] rpc);
    logic iss;
    if (r) begin
      m_q.delete(); m_inf = 1'b0; m_pcf = B;
    end else if (fl) begin
      m_q.delete(); m_inf = 1'b1; m_inf_pc = rpc; m_pcf = rpc + 32'd4;
    end else begin
      iss = m_issue(we, fl);
      if (m_q.size() > 0 && we) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_inf_pc);
      if (iss) begin
        m_inf = 1'b1; m_inf_pc = m_pcf; m_pcf = m_pcf + 32'd4;
      end else m_inf = 1'b0;
    end
  endfunction

  initial begin
    bus.id_write_en = 1'b1;
    bus.id_flush    = 1'b0;
    bus.redirect_pc = 32'd0;

    // Free run, 5-cycle stall, flush while full, double redirect, wrap, misalign
    add(1,0,0,        0,0,          1,B);
    add(1,0,0,        0,0,          1,B+32'h4);
    add(1,0,0,        1,B,          1,B+32'h8);
    add(1,0,0,        1,B+32'h4,    1,B+32'hc);
    add(1,0,0,        1,B+32'h8,    1,B+32'h10);
    add(1,0,0,        1,B+32'hc,    1,B+32'h14);
    for (int k = 0; k < 5; k++) add(0,0,0, 1,B+32'h10, 0,0);
    add(1,0,0,        1,B+32'h10,   1,B+32'h18);
    add(1,0,0,        1,B+32'h14,   1,B+32'h1c);
    add(0,0,0,        1,B+32'h18,   0,0);
    add(0,0,0,        1,B+32'h18,   0,0);
    add(0,1,B+32'h100,1,B+32'h18,   1,B+32'h100);
    add(0,0,0,        0,0,          1,B+32'h104);
    add(0,0,0,        1,B+32'h100,  0,0);
    add(1,0,0,        1,B+32'h100,  1,B+32'h108);
    add(1,0,0,        1,B+32'h104,  1,B+32'h10c);
    add(1,1,B+32'h200,1,B+32'h108,  1,B+32'h200);
    add(1,1,B+32'h300,0,0,          1,B+32'h300);
    add(1,0,0,        0,0,          1,B+32'h304);
    add(1,0,0,        1,B+32'h300,  1,B+32'h308);
    add(1,0,0,        1,B+32'h304,  1,B+32'h30c);
    add(1,1,32'hffff_fffc, 1,B+32'h308, 1,32'hffff_fffc);
    add(1,0,0,        0,0,          1,32'h0);
    add(1,0,0,        1,32'hffff_fffc, 1,32'h4);
    add(1,0,0,        1,32'h0,      1,32'h8);
    add(1,1,B+32'h102,1,32'h4,      1,B+32'h100);
    add(0,0,0,        0,0,          1,B+32'h104);

    // Reset state
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    chk_outputs("reset", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(0, vecs[i].we, vecs[i].fl, vecs[i].rpc);
      chk_outputs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc, vecs[i].en, vecs[i].addr);
      chk($sformatf("vec%0d addr_lsb", i), {30'd0, bus.inst_sram_addr[1:0]}, 32'd0);
    end

    // Fill the FIFO under stall, then reset with entries buffered
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("pre-reset if_valid", {31'd0, bus.if_valid}, 32'd1);
    drive(1, 0, 0, 0);
    chk("in-reset sram_en", {31'd0, bus.inst_sram_en}, 32'd0);
    drive(0, 1, 0, 0);
    chk_outputs("post-reset c0", 0, 0, 1, B);
    drive(0, 1, 0, 0);
    chk_outputs("post-reset c1", 0, 0, 1, B + 32'h4);
    drive(0, 1, 0, 0);
    chk_outputs("post-reset c2", 1, B, 1, B + 32'h8);

    // Randomized traffic against the reference model
    drive(1, 1, 0, 0);
    @(posedge clk);
    m_step(1'b1, 1'b1, 1'b0, 32'd0);
    for (int c = 0; c < 3000; c++) begin
      logic        r, we, fl, en;
      logic [31:0] rpc;
      int          sel;
      r   = ($urandom_range(99) < 2);
      we  = ($urandom_range(99) < 70);
      fl  = ($urandom_range(99) < 10);
      sel = $urandom_range(9);
      rpc = (sel == 0) ? 32'hffff_fff8 : (sel == 1) ? 32'hffff_fffc : ($urandom() & 32'hffff_fffc);
      drive(r, we, fl, rpc);
      en = !r && m_issue(we, fl);
      chk_outputs($sformatf("rand%0d", c), m_q.size() > 0, (m_q.size() > 0) ? m_q[0] : 32'd0,
                  en, fl ? rpc : m_pcf);
      @(posedge clk);
      m_step(r, we, fl, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
